booth_mul_arbiter: RTL and testbench
====================================

BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (legal 2..8).
REQ-002 Parameter WIDTH, default 8, operand width in bits; product width 2*WIDTH.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  N_REQ  per-requester operation request.
REQ-006 req_a  input  N_REQ*WIDTH  multiplicand per requester; slice i is bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  N_REQ*WIDTH  multiplier per requester; same slicing as req_a.
REQ-008 req_ready  output  N_REQ  one-hot accept strobe.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  result consumer ready.
REQ-011 rsp_id  output  $clog2(N_REQ)  requester index owning the result.
REQ-012 rsp_prod  output  2*WIDTH  signed product.
REQ-013 rsp_err  output  1  operation aborted by timeout.
REQ-014 mul_start  output  1  level start to the shared Booth core; low resets the core.
REQ-015 mul_m, mul_q  output  WIDTH each  operands to the core.
REQ-016 mul_done  input  1  core completion flag.
REQ-017 mul_prod  input  2*WIDTH  core product; valid while mul_done is high.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, RESP.
REQ-020 IDLE: the winner SHALL be the first requester with req_valid high, searching from rr_ptr upward with wrap at N_REQ.
REQ-021 req_ready[winner] SHALL be high combinationally in IDLE only; all other bits low; all zero when no request.
REQ-022 On an IDLE cycle with a winner, the block SHALL register the winner's req_a/req_b and winner index, set rr_ptr = (winner+1) mod N_REQ, and enter RUN.
REQ-023 mul_start SHALL be low in IDLE and RESP and high in RUN; mul_m/mul_q SHALL drive the registered operands.
REQ-024 RUN: on mul_done high the block SHALL register mul_prod into rsp_prod, clear rsp_err, and enter RESP; mul_done SHALL be ignored outside RUN.
REQ-025 RESP: rsp_valid SHALL be high; rsp_id/rsp_prod/rsp_err SHALL stay stable until rsp_valid&rsp_ready, then the FSM SHALL return to IDLE.
REQ-026 No req_ready SHALL assert in RUN or RESP; withdrawing req_valid before acceptance SHALL be legal with no side effect.
REQ-027 Minimum occupancy per operation: 1 IDLE cycle + RUN until mul_done + 1 RESP cycle; mul_start SHALL therefore be low for at least 2 cycles between operations.

Reset
REQ-028 On rst_n low the block SHALL immediately enter IDLE with rr_ptr=0, rsp_valid=0, rsp_prod=0, rsp_id=0, rsp_err=0, mul_start=0, operand registers 0, busy=0, and timeout counter 0.
REQ-029 A reset during RUN SHALL discard the operation; no response SHALL be produced for it.

Configuration
REQ-030 With BOOTH_ARB_TIMEOUT_EN defined, a counter SHALL clear on RUN entry, increment each RUN cycle, and on reaching 4*WIDTH+8 without mul_done force RESP with rsp_err=1 and rsp_prod=0.
REQ-031 Without BOOTH_ARB_TIMEOUT_EN, rsp_err SHALL be constant 0, no counter SHALL exist, and RUN SHALL wait indefinitely.

Structure
REQ-032 A shared package booth_pkg SHALL hold the FSM state typedef (IDLE, RUN, RESP) and the timeout limit function of WIDTH.
REQ-033 Round-robin winner selection SHALL be a sub-module rr_arbiter (inputs req vector and pointer, output one-hot grant and index).

Verification (N_REQ=4, WIDTH=8, behavioural Booth model on mul_*)
REQ-034 req_valid=4'b0001, a=8'd3, b=8'hFE -> req_ready=4'b0001 for one cycle, then rsp_valid with rsp_id=0, rsp_prod=16'hFFFA, rsp_err=0.
REQ-035 req_valid=4'b1111 held after reset -> grants in order 0,1,2,3,0 with rsp_id matching each.
REQ-036 After grant to requester 1, req_valid=4'b1010 -> next grant is 3, not 1.
REQ-037 rsp_ready low for 5 cycles in RESP -> rsp_valid/rsp_id/rsp_prod stable, req_ready=0 throughout.
REQ-038 rst_n low in RUN -> mul_start and busy low same cycle, no rsp_valid afterwards, next grant starts from requester 0.
REQ-039 mul_done held low, macro defined -> rsp_valid with rsp_err=1, rsp_prod=0 after 40 RUN cycles; macro undefined -> busy stays high, no response.

Source files
------------

// File: rtl/booth_mul_arbiter_pkg.sv
// booth_pkg: shared types and constants for the Booth multiplier arbiter.
//   state_t        : arbiter FSM states (IDLE, RUN, RESP)
//   timeout_limit  : RUN-cycle budget before an operation is aborted,
//                    used only when BOOTH_ARB_TIMEOUT_EN is defined
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

   // A radix-2 Booth core needs about 2*WIDTH cycles; double it plus slack.
   function automatic int timeout_limit(input int width);
      return 4 * width + 8;
   endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: bundles the requester bus, the response bus and the
// shared Booth core handshake.
//   slave  : arbiter side (drives req_ready, rsp_*, mul_start/m/q)
//   master : environment side (drives req_*, rsp_ready, mul_done/prod)
interface booth_mul_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   localparam int IDW = $clog2(N_REQ);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [2*WIDTH-1:0]     rsp_prod;
   logic                   rsp_err;
   logic                   mul_start;
   logic [WIDTH-1:0]       mul_m;
   logic [WIDTH-1:0]       mul_q;
   logic                   mul_done;
   logic [2*WIDTH-1:0]     mul_prod;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_prod,
      output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err,
             mul_start, mul_m, mul_q
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, mul_done, mul_prod,
      input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err,
             mul_start, mul_m, mul_q
   );

endinterface

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin winner search.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot grant (zero when no request)
//   idx : index of the granted requester
//   any : at least one request present
module rr_arbiter #(
   parameter int N_REQ = 4,
   localparam int IDW  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDW-1:0]   idx,
   output logic             any
);

   // Scan offsets from farthest to nearest so the requester closest to ptr
   // (walking upward with wrap) is the last one to overwrite idx.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         int j;
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (req[j]) begin
            idx = IDW'(j);
            any = 1'b1;
         end
      end
      if (any) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: shares one Booth multiplier core among N_REQ requesters.
// One operation at a time: IDLE picks a round-robin winner, RUN holds
// mul_start high until the core reports done, RESP presents the result until
// the consumer takes it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : booth_mul_arbiter_if.slave (requests, response, core port)
//   busy       : high whenever the FSM is not in IDLE
// Optional: define BOOTH_ARB_TIMEOUT_EN to abort a RUN that lasts
// timeout_limit(WIDTH) cycles with rsp_err=1 and rsp_prod=0.
module booth_mul_arbiter
   import booth_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   booth_mul_arbiter_if.slave   bus,
   output logic                 busy
);

   localparam int IDW = $clog2(N_REQ);

   state_t             state, state_nxt;
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     id_q;
   logic [WIDTH-1:0]   op_m, op_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [N_REQ-1:0]   win_gnt;
   logic [IDW-1:0]     win_idx;
   logic               win_any;
   logic               timeout;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req (bus.req_valid),
      .ptr (rr_ptr),
      .gnt (win_gnt),
      .idx (win_idx),
      .any (win_any)
   );

`ifdef BOOTH_ARB_TIMEOUT_EN
   localparam int TO_LIM = timeout_limit(WIDTH);
   localparam int CW     = $clog2(TO_LIM + 1);

   logic [CW-1:0] to_cnt;
   logic          err_q;

   // Counter holds k-1 during the k-th RUN cycle, so the abort fires on
   // exactly the TO_LIM-th RUN cycle. It is zero outside RUN, hence zero
   // on RUN entry.
   assign timeout = (state == RUN) && !bus.mul_done && (to_cnt == CW'(TO_LIM - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            to_cnt <= '0;
      else if (state == RUN) to_cnt <= to_cnt + 1'b1;
      else                   to_cnt <= '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else if (state == RUN) begin
         if (bus.mul_done)  err_q <= 1'b0;
         else if (timeout)  err_q <= 1'b1;
      end
   end

   assign bus.rsp_err = err_q;
`else
   assign timeout     = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.req_ready = '0;
      bus.rsp_valid = 1'b0;
      bus.mul_start = 1'b0;
      busy          = 1'b1;
      case (state)
         IDLE: begin
            busy          = 1'b0;
            bus.req_ready = win_gnt;
            if (win_any) state_nxt = RUN;
         end
         RUN: begin
            bus.mul_start = 1'b1;
            if (bus.mul_done || timeout) state_nxt = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operands, owner id and product are captured once per operation and
   // held, so rsp_* stay stable throughout RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
         id_q   <= '0;
         op_m   <= '0;
         op_q   <= '0;
         prod_q <= '0;
      end else begin
         case (state)
            IDLE: if (win_any) begin
               op_m   <= bus.req_a[win_idx*WIDTH +: WIDTH];
               op_q   <= bus.req_b[win_idx*WIDTH +: WIDTH];
               id_q   <= win_idx;
               rr_ptr <= (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            RUN: begin
               if (bus.mul_done)  prod_q <= bus.mul_prod;
               else if (timeout)  prod_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.mul_m    = op_m;
   assign bus.mul_q    = op_q;
   assign bus.rsp_id   = id_q;
   assign bus.rsp_prod = prod_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Randomized scoreboard bench for booth_mul_arbiter (N_REQ=4, WIDTH=8) with
// a behavioural multiplier core model on the mul_* port.
module tb_booth_mul_arbiter;

   localparam int N_REQ = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   typedef struct {
      logic [IDW-1:0]     id;
      logic [2*WIDTH-1:0] prod;
      logic               err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;

   always #5 clk = ~clk;

   booth_mul_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

   booth_mul_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   int checks = 0;
   int failures = 0;

   exp_t sb[$];
   int   gnt_log[$];
   logic [2*WIDTH-1:0] rsp_prod_log[$];
   logic [IDW-1:0]     rsp_id_log[$];
   logic               rsp_err_log[$];

   bit stall = 1'b0;
   bit drop_on_grant = 1'b1;
   int rdy_mode = 0;
   int last_grant = -1;
   bit m_free = 1'b1;
   int m_ptr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural core: after a random latency following mul_start, presents
   // the signed product of mul_m*mul_q. While mul_start is low it drives
   // random junk on mul_done/mul_prod, which the arbiter must ignore.
   int  lat, lat_cnt;
   bit  armed = 1'b0;
   always @(posedge clk) begin
      #1;
      if (!bus.mul_start) begin
         armed        = 1'b0;
         bus.mul_done = ($urandom % 4 == 0);
         bus.mul_prod = 16'($urandom);
      end else begin
         if (!armed) begin
            armed        = 1'b1;
            bus.mul_done = 1'b0;
            lat_cnt      = 0;
            lat          = $urandom_range(0, 5);
         end
         if (!stall && !bus.mul_done) begin
            if (lat_cnt >= lat) begin
               bus.mul_done = 1'b1;
               bus.mul_prod = $signed(bus.mul_m) * $signed(bus.mul_q);
            end else lat_cnt++;
         end
      end
   end

   // Reference model: one operation in flight; round-robin from a pointer
   // that moves past each winner; free again after the response is taken.
   always @(negedge clk) begin : model
      int w;
      logic [N_REQ-1:0] exp_rdy;
      logic signed [WIDTH-1:0] sa, sbv;
      exp_t e;
      if (!rst_n) begin
         m_free = 1'b1;
         m_ptr = 0;
         last_grant = -1;
         sb.delete();
      end else begin
         w = -1;
         if (m_free)
            for (int k = 0; k < N_REQ; k++)
               if (w < 0 && bus.req_valid[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
         exp_rdy = '0;
         if (w >= 0) exp_rdy[w] = 1'b1;
         chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
         chk("busy", 32'(busy), 32'(!m_free));
         last_grant = w;
         if (w >= 0) begin
            sa = bus.req_a[w*WIDTH +: WIDTH];
            sbv = bus.req_b[w*WIDTH +: WIDTH];
            e.id = IDW'(w);
            e.prod = sa * sbv;
            e.err = 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            if (stall) begin
               e.prod = '0;
               e.err = 1'b1;
            end
`endif
            sb.push_back(e);
            gnt_log.push_back(w);
            m_ptr = (w + 1) % N_REQ;
            m_free = 1'b0;
         end else if (bus.rsp_valid && bus.rsp_ready) begin
            m_free = 1'b1;
         end
      end
   end

   // Monitor: stability while stalled, compare on each response handshake.
   logic               hold_v = 1'b0;
   logic [IDW-1:0]     hold_id;
   logic [2*WIDTH-1:0] hold_prod;
   logic               hold_err;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) hold_v = 1'b0;
      else if (bus.rsp_valid) begin
         chk("mul_start_in_resp", 32'(bus.mul_start), 32'd0);
         if (hold_v) begin
            chk("rsp_id_stable", 32'(bus.rsp_id), 32'(hold_id));
            chk("rsp_prod_stable", 32'(bus.rsp_prod), 32'(hold_prod));
            chk("rsp_err_stable", 32'(bus.rsp_err), 32'(hold_err));
         end
         if (bus.rsp_ready) begin
            rsp_id_log.push_back(bus.rsp_id);
            rsp_prod_log.push_back(bus.rsp_prod);
            rsp_err_log.push_back(bus.rsp_err);
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rsp_unexpected actual id=%0d prod=%0h required=no response", bus.rsp_id, bus.rsp_prod);
            end else begin
               e = sb.pop_front();
               chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
               chk("rsp_prod", 32'(bus.rsp_prod), 32'(e.prod));
               chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
            hold_v = 1'b0;
         end else begin
            hold_v = 1'b1;
            hold_id = bus.rsp_id;
            hold_prod = bus.rsp_prod;
            hold_err = bus.rsp_err;
         end
      end else hold_v = 1'b0;
   end

   task automatic cycle();
      @(posedge clk);
      #1;
      if (last_grant >= 0) begin
         bus.req_a[last_grant*WIDTH +: WIDTH] = WIDTH'($urandom);
         bus.req_b[last_grant*WIDTH +: WIDTH] = WIDTH'($urandom);
         if (drop_on_grant) bus.req_valid[last_grant] = 1'b0;
      end
      case (rdy_mode)
         0:       bus.rsp_ready = 1'b1;
         1:       bus.rsp_ready = ($urandom % 3 != 0);
         default: bus.rsp_ready = 1'b0;
      endcase
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.req_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_grants(input int n, input string name);
      int c = 0;
      while (gnt_log.size() < n && c < 200) begin
         cycle();
         c++;
      end
      chk(name, 32'(gnt_log.size() >= n), 32'd1);
   endtask

   task automatic wait_rsps(input int n, input string name);
      int c = 0;
      while (rsp_prod_log.size() < n && c < 200) begin
         cycle();
         c++;
      end
      chk(name, 32'(rsp_prod_log.size() >= n), 32'd1);
   endtask

   task automatic drain(input int n);
      bus.req_valid = '0;
      rdy_mode = 0;
      repeat (n) cycle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int base, rbase, c, seen, runc;
      logic [IDW-1:0] sid;
      logic [2*WIDTH-1:0] sprod;

      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.rsp_ready = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mul_start", 32'(bus.mul_start), 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_rsp_prod", 32'(bus.rsp_prod), 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_mul_m", 32'(bus.mul_m), 32'd0);
      chk("rst_mul_q", 32'(bus.mul_q), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single request: 3 * -2
      rbase = rsp_prod_log.size();
      bus.req_a[7:0] = 8'd3;
      bus.req_b[7:0] = 8'hFE;
      bus.req_valid = 4'b0001;
      wait_rsps(rbase + 1, "single_rsp_seen");
      if (rsp_prod_log.size() > rbase) begin
         chk("single_prod", 32'(rsp_prod_log[rbase]), 32'h0000FFFA);
         chk("single_id", 32'(rsp_id_log[rbase]), 32'd0);
         chk("single_err", 32'(rsp_err_log[rbase]), 32'd0);
      end
      drain(10);

      // All requesting continuously: rotation 0,1,2,3,0
      do_reset();
      base = gnt_log.size();
      drop_on_grant = 1'b0;
      bus.req_valid = 4'b1111;
      wait_grants(base + 5, "rotation_grants");
      if (gnt_log.size() >= base + 5)
         for (int i = 0; i < 5; i++) chk("rotation_order", 32'(gnt_log[base+i]), 32'(i % N_REQ));
      drop_on_grant = 1'b1;
      drain(40);

      // Pointer moves past the winner
      do_reset();
      base = gnt_log.size();
      bus.req_valid = 4'b0010;
      wait_grants(base + 1, "ptr_first_grant");
      bus.req_valid = 4'b1010;
      wait_grants(base + 2, "ptr_second_grant");
      if (gnt_log.size() >= base + 2) begin
         chk("ptr_first", 32'(gnt_log[base]), 32'd1);
         chk("ptr_second", 32'(gnt_log[base+1]), 32'd3);
      end
      drain(40);

      // Back-pressure in RESP with other requesters waiting
      rdy_mode = 2;
      bus.req_valid = 4'b0100;
      c = 0;
      while (!bus.rsp_valid && c < 40) begin
         cycle();
         c++;
      end
      chk("bp_resp_reached", 32'(bus.rsp_valid), 32'd1);
      sid = bus.rsp_id;
      sprod = bus.rsp_prod;
      bus.req_valid = 4'b1111;
      repeat (5) cycle();
      chk("bp_still_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_id_held", 32'(bus.rsp_id), 32'(sid));
      chk("bp_prod_held", 32'(bus.rsp_prod), 32'(sprod));
      chk("bp_id_owner", 32'(bus.rsp_id), 32'd2);
      rdy_mode = 0;
      repeat (60) cycle();
      drain(20);

      // Random traffic with random back-pressure and withdrawals
      rdy_mode = 1;
      repeat (600) begin
         cycle();
         if ($urandom % 3 == 0) bus.req_valid[$urandom % N_REQ] = 1'b1;
         if ($urandom % 10 == 0) bus.req_valid[$urandom % N_REQ] = 1'b0;
      end
      drain(60);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      // Reset during RUN
      do_reset();
      stall = 1'b1;
      bus.req_valid = 4'b0100;
      c = 0;
      while (!bus.mul_start && c < 20) begin
         cycle();
         c++;
      end
      chk("run_reached", 32'(bus.mul_start), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_run_mul_start", 32'(bus.mul_start), 32'd0);
      chk("rst_run_busy", 32'(busy), 32'd0);
      chk("rst_run_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      stall = 1'b0;
      bus.req_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         cycle();
         if (bus.rsp_valid) seen++;
      end
      chk("rst_run_no_rsp", 32'(seen), 32'd0);
      base = gnt_log.size();
      bus.req_valid = 4'b1111;
      wait_grants(base + 1, "rst_run_grant");
      if (gnt_log.size() > base) chk("rst_run_first_grant", 32'(gnt_log[base]), 32'd0);
      drain(60);

      // Core never completes
      do_reset();
      stall = 1'b1;
      rbase = rsp_prod_log.size();
      runc = 0;
      bus.req_valid = 4'b0001;
      repeat (70) begin
         cycle();
         if (bus.mul_start) runc++;
      end
`ifdef BOOTH_ARB_TIMEOUT_EN
      chk("timeout_rsp_count", 32'(rsp_prod_log.size() - rbase), 32'd1);
      chk("timeout_run_cycles", 32'(runc), 32'd40);
      if (rsp_prod_log.size() > rbase) begin
         chk("timeout_err", 32'(rsp_err_log[rbase]), 32'd1);
         chk("timeout_prod", 32'(rsp_prod_log[rbase]), 32'd0);
      end
`else
      chk("stuck_busy", 32'(busy), 32'd1);
      chk("stuck_mul_start", 32'(bus.mul_start), 32'd1);
      chk("stuck_no_rsp", 32'(rsp_prod_log.size() - rbase), 32'd0);
`endif
      stall = 1'b0;
      do_reset();
      drain(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
